// File: rtl/serial_rx.sv
// UART-style receiver: 1 start, DATA_WIDTH data bits LSB first, optional even parity, 1 stop.
// Optional parity stage is built when SERIAL_RX_PARITY_EN is defined; outputs are registered.
module serial_rx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  parity_err
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW   = $clog2(DATA_WIDTH) + 1;

  localparam logic [CW-1:0] HALF_C  = CW'(HALF);
  localparam logic [CW-1:0] LAST_C  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] TOP_BIT = BW'(DATA_WIDTH - 1);

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE, PARITY} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

  state_t                  state_q;
  logic                    rx_m_q;
  logic                    rx_s_q;
  logic [CW-1:0]           cnt_q;
  logic [BW-1:0]           bit_idx_q;
  logic [DATA_WIDTH-1:0]   shreg_q;
  logic [DATA_WIDTH-1:0]   shreg_d;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    valid_q;
  logic                    busy_q;
  logic                    frame_err_q;
  logic                    bit_tick;
`ifdef SERIAL_RX_PARITY_EN
  logic                    par_q;
  logic                    parity_err_q;
  logic                    parity_ok;
`endif

  assign bit_tick = (cnt_q == LAST_C);
  // Right shift: the first (LSB) bit received ends up at bit 0 after DATA_WIDTH samples.
  assign shreg_d  = {rx_s_q, shreg_q[DATA_WIDTH-1:1]};

`ifdef SERIAL_RX_PARITY_EN
  assign parity_ok = ((^shreg_q) == par_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rx_m_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_m_q      <= rx;
      rx_s_q      <= rx_m_q;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == HALF_C) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            if (rx_s_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (bit_tick) begin
            cnt_q     <= '0;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_q + BW'(1);
            if (bit_idx_q == TOP_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            cnt_q   <= '0;
            par_q   <= rx_s_q;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`endif
        STOP: begin
          if (bit_tick) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
              if (parity_ok) begin
                data_q  <= shreg_q;
                valid_q <= 1'b1;
              end else begin
                parity_err_q <= 1'b1;
              end
`else
              data_q  <= shreg_q;
              valid_q <= 1'b1;
`endif
            end else begin
              // Bad stop bit: report once, then wait out a possible break.
              frame_err_q <= 1'b1;
              state_q     <= WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rx_s_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
`ifdef SERIAL_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: frame table on a CLKS_PER_BIT=2 receiver, plus glitch,
// 4-clk/bit reception and mid-frame reset sequences.
module tb_serial_rx;

`ifdef SERIAL_RX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif
  // Busy spans start detection to stop sample: (FL-1)*CPB + HALF + 1 cycles with CPB=2, HALF=0.
  localparam int BUSY_EXP = (FL - 1) * 2 + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       rx4;
  logic [7:0] data,  data4;
  logic       valid, busy, frame_err, parity_err;
  logic       valid4, busy4, frame_err4, parity_err4;

  int total = 0;
  int bad   = 0;

  int vcnt = 0, fcnt = 0, pcnt = 0, bcnt = 0, vwide = 0, overlap = 0;
  int vcnt4 = 0, fcnt4 = 0, bcnt4 = 0;
  logic pv = 1'b0;

  always #5 clk = ~clk;

  serial_rx #(.DATA_WIDTH(8), .CLKS_PER_BIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data(data), .valid(valid),
    .busy(busy), .frame_err(frame_err), .parity_err(parity_err));

  serial_rx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .rx(rx4), .data(data4), .valid(valid4),
    .busy(busy4), .frame_err(frame_err4), .parity_err(parity_err4));

  always @(negedge clk) begin
    if (valid)                 vcnt    <= vcnt + 1;
    if (frame_err)             fcnt    <= fcnt + 1;
    if (parity_err)            pcnt    <= pcnt + 1;
    if (busy)                  bcnt    <= bcnt + 1;
    if (valid && pv)           vwide   <= vwide + 1;
    if (valid && frame_err)    overlap <= overlap + 1;
    pv <= valid;
    if (valid4)     vcnt4 <= vcnt4 + 1;
    if (frame_err4) fcnt4 <= fcnt4 + 1;
    if (busy4)      bcnt4 <= bcnt4 + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] mk(input logic [7:0] d, input logic stopb);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef SERIAL_RX_PARITY_EN
    f[9]  = ^d;
    f[10] = stopb;
`else
    f[9]  = stopb;
`endif
    return f;
  endfunction

  // Drives frame bits lo..hi starting right after a falling clock edge.
  task automatic send_range(input logic [11:0] f, input int lo, input int hi, input bit on4);
    for (int i = lo; i <= hi; i++) begin
      if (on4) rx4 = f[i];
      else     rx  = f[i];
      repeat (on4 ? 4 : 2) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stopb;
    logic       flip;
    int         low_after;
    int         idle_after;
    int         add_v;
    int         add_f;
    int         add_p;
    logic       chk;
    logic       chk_busy;
    logic [7:0] exp_data;
  } row_t;

  row_t rows[$];

  initial begin
    logic [11:0] f;
    int ev, ef, ep, b0, v0, fc;

    rows.push_back('{8'hA5, 1'b1, 1'b0, 0,  8, 1, 0, 0, 1'b1, 1'b1, 8'hA5});
    rows.push_back('{8'h00, 1'b1, 1'b0, 0,  0, 1, 0, 0, 1'b0, 1'b0, 8'h00});
    rows.push_back('{8'hFF, 1'b1, 1'b0, 0,  8, 1, 0, 0, 1'b1, 1'b0, 8'hFF});
    rows.push_back('{8'h3C, 1'b0, 1'b0, 40, 8, 0, 1, 0, 1'b1, 1'b0, 8'hFF});
    rows.push_back('{8'h81, 1'b1, 1'b0, 0,  8, 1, 0, 0, 1'b1, 1'b0, 8'h81});
    rows.push_back('{8'h0F, 1'b1, 1'b0, 0,  8, 1, 0, 0, 1'b1, 1'b0, 8'h0F});
`ifdef SERIAL_RX_PARITY_EN
    rows.push_back('{8'h07, 1'b1, 1'b0, 0,  8, 1, 0, 0, 1'b1, 1'b0, 8'h07});
    rows.push_back('{8'h07, 1'b1, 1'b1, 0,  8, 0, 0, 1, 1'b1, 1'b0, 8'h07});
`endif

    rst_n = 1'b0;
    rx    = 1'b1;
    rx4   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data",       data,       0);
    check("reset_valid",      valid,      0);
    check("reset_busy",       busy,       0);
    check("reset_frame_err",  frame_err,  0);
    check("reset_parity_err", parity_err, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    ev = 0; ef = 0; ep = 0;
    foreach (rows[k]) begin
      b0 = bcnt;
      f  = mk(rows[k].d, rows[k].stopb);
`ifdef SERIAL_RX_PARITY_EN
      if (rows[k].flip) f[9] = ~f[9];
`endif
      send_range(f, 0, FL - 1, 1'b0);
      rx = 1'b0;
      repeat (rows[k].low_after) @(negedge clk);
      rx = 1'b1;
      repeat (rows[k].idle_after) @(negedge clk);
      ev += rows[k].add_v;
      ef += rows[k].add_f;
      ep += rows[k].add_p;
      if (rows[k].chk) begin
        check($sformatf("row%0d_valid_count", k), vcnt, ev);
        check($sformatf("row%0d_frame_err_count", k), fcnt, ef);
        check($sformatf("row%0d_parity_err_count", k), pcnt, ep);
        check($sformatf("row%0d_data", k), data, rows[k].exp_data);
        check($sformatf("row%0d_busy_idle", k), busy, 0);
      end
      if (rows[k].chk_busy) check($sformatf("row%0d_busy_cycles", k), bcnt - b0, BUSY_EXP);
    end
    check("valid_single_cycle", vwide, 0);
    check("valid_frame_err_overlap", overlap, 0);

    // One-clock low glitch on the 4-clk/bit receiver.
    rx4 = 1'b0;
    @(negedge clk);
    rx4 = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_valid", vcnt4, 0);
    check("glitch_frame_err", fcnt4, 0);
    check("glitch_busy_cycles", bcnt4, 2);
    check("glitch_busy_low", busy4, 0);

    send_range(mk(8'hC3, 1'b1), 0, FL - 1, 1'b1);
    repeat (12) @(negedge clk);
    check("cpb4_valid", vcnt4, 1);
    check("cpb4_data", data4, 8'hC3);

    // Reset pulse during data bit 4 of 0x5A.
    fc = fcnt;
    f  = mk(8'h5A, 1'b1);
    send_range(f, 0, 4, 1'b0);
    rx = f[5];
    #2 rst_n = 1'b0;
    #1;
    check("midreset_data",       data,       0);
    check("midreset_valid",      valid,      0);
    check("midreset_busy",       busy,       0);
    check("midreset_frame_err",  frame_err,  0);
    check("midreset_parity_err", parity_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_range(f, 6, FL - 1, 1'b0);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("midreset_no_frame_err", fcnt, fc);
    v0 = vcnt;
    send_range(mk(8'h12, 1'b1), 0, FL - 1, 1'b0);
    repeat (8) @(negedge clk);
    check("after_reset_valid", vcnt, v0 + 1);
    check("after_reset_data", data, 8'h12);
    check("final_valid_single_cycle", vwide, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
